mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction/data) arbiter for a single-outstanding shared memory port
module mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_addr,
  input  logic [31:0] dreq_data,
  input  logic [1:0]  dreq_size,
  input  logic [3:0]  dreq_strobe,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [31:0] dresp_data,
  output logic        mreq_valid,
  output logic        mreq_is_write,
  output logic [31:0] mreq_addr,
  output logic [31:0] mreq_data,
  output logic [1:0]  mreq_size,
  output logic [3:0]  mreq_strobe,
  input  logic        mresp_addr_ok,
  input  logic        mresp_data_ok,
  input  logic [31:0] mresp_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic gnt_d_q, gnt_d_d, pick_d, addr_ok, data_ok;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [1:0] size_q, size_d;
  logic [3:0] strobe_q, strobe_d;
  always_comb begin
    state_d = state_q;
    gnt_d_d = gnt_d_q;
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    strobe_d = strobe_q;
    pick_d = dreq_valid && (DATA_FIRST || !ireq_valid);
    addr_ok = state_q == ADDR && mresp_addr_ok;
    data_ok = (addr_ok || state_q == DATA) && mresp_data_ok;
    if (state_q == IDLE && (ireq_valid || dreq_valid)) begin
      state_d = ADDR;
      gnt_d_d = pick_d;
      addr_d = pick_d ? dreq_addr : ireq_addr;
      data_d = pick_d ? dreq_data : '0;
      size_d = pick_d ? dreq_size : 2'b10;
      strobe_d = pick_d ? dreq_strobe : '0;
    end else if (data_ok) begin
      state_d = IDLE;
    end else if (addr_ok) begin
      state_d = DATA;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_d_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      strobe_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_d_q <= gnt_d_d;
      addr_q <= addr_d;
      data_q <= data_d;
      size_q <= size_d;
      strobe_q <= strobe_d;
    end
  end
  assign busy = state_q != IDLE;
  assign mreq_valid = state_q == ADDR;
  assign mreq_is_write = mreq_valid && |strobe_q;
  assign mreq_addr = mreq_valid ? addr_q : '0;
  assign mreq_data = mreq_valid ? data_q : '0;
  assign mreq_size = mreq_valid ? size_q : '0;
  assign mreq_strobe = mreq_valid ? strobe_q : '0;
  assign iresp_addr_ok = addr_ok && !gnt_d_q;
  assign dresp_addr_ok = addr_ok && gnt_d_q;
  assign iresp_data_ok = data_ok && !gnt_d_q;
  assign dresp_data_ok = data_ok && gnt_d_q;
  assign iresp_data = iresp_data_ok ? mresp_data : '0;
  assign dresp_data = dresp_data_ok ? mresp_data : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks instruction-first and data-first arbiters against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] iv, dv;
  logic [31:0] ia [2];
  logic [31:0] da [2];
  logic [31:0] dd [2];
  logic [1:0] dsz [2];
  logic [3:0] dst [2];
  logic mao, mdo;
  logic [31:0] mrd;
  logic [1:0] mv, miw, iaok, idok, daok, ddok, bsy;
  logic [1:0] msz [2];
  logic [3:0] mst [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [31:0] idat [2];
  logic [31:0] ddat [2];
  int checks = 0;
  int fails = 0;
  bit r_v [2];
  bit r_d [2];
  bit r_acc [2];
  logic [31:0] r_a [2];
  logic [31:0] r_w [2];
  logic [1:0] r_s [2];
  logic [3:0] r_st [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    mem_arbiter #(.DATA_FIRST(g == 1)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(iv[g]), .ireq_addr(ia[g]),
      .iresp_addr_ok(iaok[g]), .iresp_data_ok(idok[g]), .iresp_data(idat[g]),
      .dreq_valid(dv[g]), .dreq_addr(da[g]), .dreq_data(dd[g]),
      .dreq_size(dsz[g]), .dreq_strobe(dst[g]),
      .dresp_addr_ok(daok[g]), .dresp_data_ok(ddok[g]), .dresp_data(ddat[g]),
      .mreq_valid(mv[g]), .mreq_is_write(miw[g]), .mreq_addr(ma[g]), .mreq_data(md[g]),
      .mreq_size(msz[g]), .mreq_strobe(mst[g]),
      .mresp_addr_ok(mao), .mresp_data_ok(mdo), .mresp_data(mrd),
      .busy(bsy[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic settle();
    bit m, ao, dk;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      m = r_v[p] && !r_acc[p];
      ao = m && mao;
      dk = r_v[p] && (r_acc[p] || mao) && mdo;
      chk($sformatf("ctrl%0d", p),
          {19'd0, mv[p], miw[p], msz[p], mst[p], iaok[p], idok[p], daok[p], ddok[p], bsy[p]},
          {19'd0, m, m && |r_st[p], m ? r_s[p] : 2'b0, m ? r_st[p] : 4'b0,
           ao && !r_d[p], dk && !r_d[p], ao && r_d[p], dk && r_d[p], r_v[p]});
      chk($sformatf("maddr%0d", p), ma[p], m ? r_a[p] : 32'd0);
      chk($sformatf("mdata%0d", p), md[p], m ? r_w[p] : 32'd0);
      chk($sformatf("idata%0d", p), idat[p], dk && !r_d[p] ? mrd : 32'd0);
      chk($sformatf("ddata%0d", p), ddat[p], dk && r_d[p] ? mrd : 32'd0);
    end
  endtask
  task automatic tick();
    bit w, ao, dk;
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      ao = r_v[p] && !r_acc[p] && mao;
      dk = r_v[p] && (r_acc[p] || mao) && mdo;
      if (reset) begin
        r_v[p] = 1'b0;
        r_acc[p] = 1'b0;
      end else if (!r_v[p]) begin
        if (iv[p] || dv[p]) begin
          w = dv[p] && (p == 1 || !iv[p]);
          r_v[p] = 1'b1;
          r_acc[p] = 1'b0;
          r_d[p] = w;
          r_a[p] = w ? da[p] : ia[p];
          r_w[p] = w ? dd[p] : 32'd0;
          r_s[p] = w ? dsz[p] : 2'b10;
          r_st[p] = w ? dst[p] : 4'd0;
        end
      end else if (dk) begin
        r_v[p] = 1'b0;
      end else if (ao) begin
        r_acc[p] = 1'b1;
      end
    end
    #1;
  endtask
  task automatic cyc();
    settle();
    tick();
  endtask
  initial begin
    reset = 1'b1;
    iv = '0;
    dv = '0;
    mao = 1'b0;
    mdo = 1'b0;
    mrd = '0;
    for (int p = 0; p < 2; p++) begin
      ia[p] = '0; da[p] = '0; dd[p] = '0; dsz[p] = '0; dst[p] = '0;
      r_v[p] = 1'b0; r_d[p] = 1'b0; r_acc[p] = 1'b0;
      r_a[p] = '0; r_w[p] = '0; r_s[p] = '0; r_st[p] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    cyc();
    reset = 1'b0;
    iv = 2'b11;
    ia[0] = 32'hbfc00000; ia[1] = 32'hbfc00000;
    cyc();
    mao = 1'b1;
    settle();
    chk("fetch_aok", iaok[1], 1);
    chk("fetch_busy1", bsy[1], 1);
    chk("fetch_no_daok", daok[1], 0);
    tick();
    iv = 2'b00;
    mao = 1'b0;
    cyc();
    mdo = 1'b1;
    mrd = 32'h24010001;
    settle();
    chk("fetch_dok", idok[1], 1);
    chk("fetch_data", idat[1], 32'h24010001);
    chk("fetch_busy3", bsy[1], 1);
    tick();
    mdo = 1'b0;
    mrd = '0;
    settle();
    chk("fetch_idle", bsy[1], 0);
    tick();
    iv = 2'b11;
    dv = 2'b11;
    for (int p = 0; p < 2; p++) begin
      ia[p] = 32'hbfc00004; da[p] = 32'h80000010; dd[p] = 32'hdeadbeef;
      dsz[p] = 2'b10; dst[p] = 4'hf;
    end
    cyc();
    mao = 1'b1;
    mdo = 1'b1;
    mrd = 32'h11111111;
    settle();
    chk("df1_write", miw[1], 1);
    chk("df1_wdata", md[1], 32'hdeadbeef);
    chk("df0_fetch", ma[0], 32'hbfc00004);
    chk("df0_read", miw[0], 0);
    chk("same_cycle_d", {daok[1], ddok[1], iaok[1], idok[1]}, 4'b1100);
    chk("same_cycle_i", {daok[0], ddok[0], iaok[0], idok[0]}, 4'b0011);
    tick();
    dv[1] = 1'b0;
    iv[0] = 1'b0;
    mao = 1'b0;
    mdo = 1'b0;
    settle();
    chk("b2b_idle", bsy, 2'b00);
    tick();
    da[0] = 32'h12345678;
    settle();
    chk("loser_fetch", ma[1], 32'hbfc00004);
    chk("loser_write", ma[0], 32'h80000010);
    chk("loser_wdata", md[0], 32'hdeadbeef);
    tick();
    da[0] = 32'h0badf00d;
    settle();
    chk("latched_addr", ma[0], 32'h80000010);
    tick();
    mao = 1'b1;
    cyc();
    iv = 2'b00;
    dv = 2'b00;
    mao = 1'b0;
    mdo = 1'b1;
    mrd = 32'h5a5a5a5a;
    cyc();
    mdo = 1'b0;
    dv = 2'b11;
    for (int p = 0; p < 2; p++) begin
      da[p] = 32'h100; dst[p] = 4'h0;
    end
    cyc();
    mao = 1'b1;
    cyc();
    dv = 2'b00;
    mao = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mdo = 1'b1;
    mrd = 32'haaaa5555;
    settle();
    chk("rst_no_dok", ddok, 2'b00);
    chk("rst_no_data", ddat[1], 0);
    chk("rst_idle", bsy, 2'b00);
    tick();
    repeat (600) begin
      for (int p = 0; p < 2; p++) begin
        iv[p] = $urandom_range(0, 1) == 1;
        dv[p] = $urandom_range(0, 1) == 1;
        ia[p] = $urandom;
        da[p] = $urandom;
        dd[p] = $urandom;
        dsz[p] = 2'($urandom_range(0, 3));
        dst[p] = 4'($urandom_range(0, 15));
      end
      mao = $urandom_range(0, 2) != 0;
      mdo = $urandom_range(0, 2) != 0;
      mrd = $urandom;
      reset = $urandom_range(0, 60) == 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
